// File: rtl/if_network_classifier_if.sv
// Host/encoder-facing bundle of the IF classifier: weight write port, run control, spikes and results.
interface if_network_classifier_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_OUTPUTS = 2,
  parameter int WEIGHT_SIZE = 8,
  parameter int CNT_SIZE    = 8,
  parameter int ADDR_SIZE   = 5,
  parameter int CLS_SIZE    = 1
);
  logic                            i_wr_en;
  logic [ADDR_SIZE-1:0]            i_wr_addr;
  logic [WEIGHT_SIZE-1:0]          i_wr_data;
  logic                            i_start;
  logic [NUM_INPUTS-1:0]           i_spike_in;
  logic                            o_busy;
  logic [NUM_OUTPUTS-1:0]          o_spike_out;
  logic [NUM_OUTPUTS*CNT_SIZE-1:0] o_spike_count;
  logic                            o_done;
  logic [CLS_SIZE-1:0]             o_class_out;
  logic                            o_class_valid;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_spike_in,
    output o_busy, o_spike_out, o_spike_count, o_done, o_class_out, o_class_valid
  );
  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start, i_spike_in,
    input  o_busy, o_spike_out, o_spike_count, o_done, o_class_out, o_class_valid
  );
endinterface

// File: rtl/if_network_classifier.sv
// Two-layer integrate-and-fire classifier: writable signed weights, fixed-length run, argmax of output spike counts.
module if_network_classifier_neuron #(
  parameter int FANIN       = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16,
  parameter int THRESH      = 15,
  parameter int RESET       = 0,
  parameter int REFRAC      = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_clr,
  input  logic                                i_en,
  input  logic [FANIN-1:0]                    i_spk,
  input  logic [FANIN-1:0][WEIGHT_SIZE-1:0]   i_w,
  output logic                                o_spike,
  output logic                                o_fire
);
  // Sum is wide enough that no combination of inputs can overflow before saturation.
  localparam int SW = POT_SIZE + WEIGHT_SIZE + $clog2(FANIN + 1);
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic signed [SW-1:0] MAXV = {{(SW-POT_SIZE+1){1'b0}}, {(POT_SIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-POT_SIZE+1){1'b1}}, {(POT_SIZE-1){1'b0}}};
  localparam logic signed [POT_SIZE-1:0] TH    = POT_SIZE'(THRESH);
  localparam logic signed [POT_SIZE-1:0] RST_V = POT_SIZE'(RESET);

  logic signed [POT_SIZE-1:0] r_pot;
  logic [RW-1:0]              r_ref;
  logic signed [SW-1:0]       w_sum;
  logic signed [POT_SIZE-1:0] w_sat;

  always_comb begin
    w_sum = SW'(r_pot);
    for (int f = 0; f < FANIN; f++)
      if (i_spk[f]) w_sum = w_sum + SW'($signed(i_w[f]));
    if (w_sum > MAXV)      w_sat = MAXV[POT_SIZE-1:0];
    else if (w_sum < MINV) w_sat = MINV[POT_SIZE-1:0];
    else                   w_sat = w_sum[POT_SIZE-1:0];
    o_fire = i_en && (r_ref == '0) && (w_sat >= TH);
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_pot   <= '0;
      r_ref   <= '0;
      o_spike <= 1'b0;
    end else if (i_en) begin
      o_spike <= o_fire;
      if (r_ref != '0) begin
        r_ref <= r_ref - 1'b1;
        r_pot <= RST_V;
      end else if (o_fire) begin
        r_pot <= RST_V;
        r_ref <= RW'(REFRAC);
      end else begin
        r_pot <= w_sat;
      end
    end else begin
      o_spike <= 1'b0;
    end
  end
endmodule

module if_network_classifier #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_HIDDEN  = 4,
  parameter int NUM_OUTPUTS = 2,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16,
  parameter int THRESH      = 15,
  parameter int RESET       = 0,
  parameter int REFRAC      = 5,
  parameter int NUM_STEPS   = 100,
  parameter int CNT_SIZE    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  if_network_classifier_if.slave  bus
);
  localparam int NW     = NUM_INPUTS*NUM_HIDDEN + NUM_HIDDEN*NUM_OUTPUTS;
  localparam int OBASE  = NUM_INPUTS*NUM_HIDDEN;
  localparam int STEP_W = $clog2(NUM_STEPS + 1);
  localparam int CLS_W  = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                                 r_state;
  logic [STEP_W-1:0]                      r_step;
  logic                                   r_busy, r_done, r_cvalid;
  logic [CLS_W-1:0]                       r_cls;
  logic [NW-1:0][WEIGHT_SIZE-1:0]         r_w;
  logic [NUM_OUTPUTS-1:0][CNT_SIZE-1:0]   r_cnt;

  logic                    w_accept, w_hen, w_oen;
  logic [NUM_HIDDEN-1:0]   w_hspk, w_hfire;
  logic [NUM_OUTPUTS-1:0]  w_ospk, w_ofire;
  logic [CLS_W-1:0]        w_cls;
  logic [CNT_SIZE-1:0]     w_best;
  logic                    w_unused;

  assign w_accept = bus.i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_hen    = (r_state == S_RUN);
  // Output layer skips the first RUN cycle: the hidden spike register is still empty then.
  assign w_oen    = (r_state == S_RUN && r_step != '0) || (r_state == S_DRAIN);
  assign w_unused = &{1'b0, w_hfire};

  always_ff @(posedge clk) begin
    if (rst)
      r_w <= '0;
    else if (bus.i_wr_en && !r_busy && int'(bus.i_wr_addr) < NW)
      r_w[bus.i_wr_addr] <= bus.i_wr_data;
  end

  for (genvar h = 0; h < NUM_HIDDEN; h++) begin : g_hid
    if_network_classifier_neuron #(
      .FANIN(NUM_INPUTS), .WEIGHT_SIZE(WEIGHT_SIZE), .POT_SIZE(POT_SIZE),
      .THRESH(THRESH), .RESET(RESET), .REFRAC(REFRAC)
    ) u_neuron (
      .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_hen),
      .i_spk(bus.i_spike_in), .i_w(r_w[h*NUM_INPUTS +: NUM_INPUTS]),
      .o_spike(w_hspk[h]), .o_fire(w_hfire[h])
    );
  end

  for (genvar o = 0; o < NUM_OUTPUTS; o++) begin : g_out
    if_network_classifier_neuron #(
      .FANIN(NUM_HIDDEN), .WEIGHT_SIZE(WEIGHT_SIZE), .POT_SIZE(POT_SIZE),
      .THRESH(THRESH), .RESET(RESET), .REFRAC(REFRAC)
    ) u_neuron (
      .clk(clk), .rst(rst), .i_clr(w_accept), .i_en(w_oen),
      .i_spk(w_hspk), .i_w(r_w[OBASE + o*NUM_HIDDEN +: NUM_HIDDEN]),
      .o_spike(w_ospk[o]), .o_fire(w_ofire[o])
    );
  end

  // Strict '>' keeps the lowest index on ties.
  always_comb begin
    w_cls  = '0;
    w_best = r_cnt[0];
    for (int o = 1; o < NUM_OUTPUTS; o++)
      if (r_cnt[o] > w_best) begin
        w_best = r_cnt[o];
        w_cls  = CLS_W'(o);
      end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_step   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cvalid <= 1'b0;
      r_cls    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      for (int o = 0; o < NUM_OUTPUTS; o++)
        if (w_ofire[o] && r_cnt[o] != '1) r_cnt[o] <= r_cnt[o] + 1'b1;
      case (r_state)
        S_RUN: begin
          r_step <= r_step + 1'b1;
          if (r_step == STEP_W'(NUM_STEPS - 1)) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end
        S_DONE: begin
          r_done   <= 1'b1;
          r_cls    <= w_cls;
          r_cvalid <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: ;
      endcase
      if (w_accept) begin
        r_state  <= S_RUN;
        r_busy   <= 1'b1;
        r_step   <= '0;
        r_cvalid <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  assign bus.o_busy        = r_busy;
  assign bus.o_spike_out   = w_ospk;
  assign bus.o_spike_count = r_cnt;
  assign bus.o_done        = r_done;
  assign bus.o_class_out   = r_cls;
  assign bus.o_class_valid = r_cvalid;
endmodule

// File: tb/tb_if_network_classifier.sv
// Directed bench: table of short runs on a 12-step instance, plus saturation runs on a 300-step, no-refractory instance.
module tb_if_network_classifier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_network_classifier_if bus ();
  if_network_classifier_if bus2 ();

  if_network_classifier #(.NUM_STEPS(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  if_network_classifier #(.NUM_STEPS(300), .REFRAC(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  spk;
    logic [7:0]  w_hi, w_o0, w_o1;
    int          c0, c1, cls;
    logic [63:0] so0, so1;
  } vec_t;
  vec_t tv[6];

  task automatic wr(input bit sel, input int a, input logic [7:0] d);
    @(negedge clk);
    if (!sel) begin bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'(a); bus.i_wr_data = d; end
    else      begin bus2.i_wr_en = 1'b1; bus2.i_wr_addr = 5'(a); bus2.i_wr_data = d; end
    @(negedge clk);
    bus.i_wr_en = 1'b0;
    bus2.i_wr_en = 1'b0;
  endtask

  // Counts edges after the start-accept edge until done; records spike_out per edge.
  task automatic wait_done(output int lat, output logic [63:0] so0, output logic [63:0] so1);
    lat = -1; so0 = '0; so1 = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.o_spike_out[0]) so0[n] = 1'b1;
      if (bus.o_spike_out[1]) so1[n] = 1'b1;
      if (bus.o_done) begin lat = n; break; end
    end
  endtask

  task automatic start_run(input logic [3:0] spk);
    @(negedge clk);
    bus.i_spike_in = spk;
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lat2, seen;
    logic [63:0] so0, so1;

    tv[0] = '{4'hF, 8'h00, 8'h00, 8'h00, 0, 0, 0, 64'h0,   64'h0};
    tv[1] = '{4'h1, 8'h10, 8'h00, 8'h10, 0, 2, 1, 64'h0,   64'h104};
    tv[2] = '{4'h1, 8'h10, 8'h10, 8'h10, 2, 2, 0, 64'h104, 64'h104};
    tv[3] = '{4'h2, 8'h10, 8'h10, 8'h10, 0, 0, 0, 64'h0,   64'h0};
    tv[4] = '{4'h1, 8'h0E, 8'h08, 8'h10, 1, 2, 1, 64'h400, 64'h408};
    tv[5] = '{4'h1, 8'h10, 8'h10, 8'hF0, 2, 0, 0, 64'h104, 64'h0};

    bus.i_wr_en = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0; bus.i_start = 0; bus.i_spike_in = 0;
    bus2.i_wr_en = 0; bus2.i_wr_addr = 0; bus2.i_wr_data = 0; bus2.i_start = 0; bus2.i_spike_in = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", bus.o_busy, 0);
    chk("rst done", bus.o_done, 0);
    chk("rst cvalid", bus.o_class_valid, 0);
    chk("rst class", bus.o_class_out, 0);
    chk("rst count", bus.o_spike_count, 0);
    chk("rst spike_out", bus.o_spike_out, 0);
    rst = 1'b0;

    foreach (tv[k]) begin
      wr(0, 0, tv[k].w_hi);
      wr(0, 16, tv[k].w_o0);
      wr(0, 20, tv[k].w_o1);
      start_run(tv[k].spk);
      wait_done(lat, so0, so1);
      chk($sformatf("v%0d latency", k), lat, 14);
      chk($sformatf("v%0d count0", k), bus.o_spike_count[7:0], tv[k].c0);
      chk($sformatf("v%0d count1", k), bus.o_spike_count[15:8], tv[k].c1);
      chk($sformatf("v%0d class", k), bus.o_class_out, tv[k].cls);
      chk($sformatf("v%0d cvalid", k), bus.o_class_valid, 1);
      chk($sformatf("v%0d so0 edges", k), so0, tv[k].so0);
      chk($sformatf("v%0d so1 edges", k), so1, tv[k].so1);
    end

    // Weight write while busy must not land.
    wr(0, 0, 8'h00); wr(0, 16, 8'h00); wr(0, 20, 8'h10);
    start_run(4'h1);
    repeat (3) @(posedge clk);
    @(negedge clk); bus.i_wr_en = 1'b1; bus.i_wr_addr = 5'd0; bus.i_wr_data = 8'h10;
    @(negedge clk); bus.i_wr_en = 1'b0;
    wait_done(lat, so0, so1);
    chk("busy-write done seen", (lat > 0), 1);
    chk("busy-write count1", bus.o_spike_count[15:8], 0);

    // Out-of-range addresses must not alias onto any weight.
    for (int a = 16; a < 24; a++) wr(0, a, 8'h10);
    wr(0, 24, 8'h10); wr(0, 28, 8'h10); wr(0, 31, 8'h10);
    start_run(4'hF);
    wait_done(lat, so0, so1);
    chk("oor count", bus.o_spike_count, 0);

    // start in RUN ignored; start in DONE restarts.
    @(negedge clk); bus.i_spike_in = 4'h0; bus.i_start = 1'b1;
    @(posedge clk); #1; bus.i_start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      bus.i_start = (n == 4 || n == 13);
      if (n == 13) chk("DONE-state busy", bus.o_busy, 0);
      if (bus.o_done) begin lat = n; break; end
    end
    bus.i_start = 1'b0;
    chk("ignored-start latency", lat, 14);
    chk("restart busy", bus.o_busy, 1);
    chk("restart cvalid cleared", bus.o_class_valid, 0);
    wait_done(lat2, so0, so1);
    chk("restart latency", lat2, 14);
    chk("restart cvalid", bus.o_class_valid, 1);

    // Reset mid-run aborts with no done pulse and clears weights.
    wr(0, 0, 8'h10);
    start_run(4'h1);
    repeat (6) @(posedge clk);
    #1;
    chk("mid-run count0", bus.o_spike_count[7:0], 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", bus.o_busy, 0);
    chk("abort count", bus.o_spike_count, 0);
    chk("abort cvalid", bus.o_class_valid, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.o_done) seen = 1; end
    chk("abort no done", seen, 0);
    start_run(4'h1);
    wait_done(lat, so0, so1);
    chk("post-reset latency", lat, 14);
    chk("post-reset weights cleared", bus.o_spike_count, 0);

    // Potential saturation then linear recovery, and count saturation with a tie.
    wr(1, 0, 8'h80); wr(1, 1, 8'h7F); wr(1, 6, 8'h10); wr(1, 17, 8'h10); wr(1, 21, 8'h10);
    @(negedge clk); bus2.i_spike_in = 4'b0101; bus2.i_start = 1'b1;
    @(posedge clk); #1; bus2.i_start = 1'b0;
    repeat (255) @(posedge clk);
    #1;
    chk("pot after 255 steps", dut2.g_hid[0].u_neuron.r_pot, -32640);
    repeat (5) @(posedge clk);
    #1;
    chk("pot saturated", dut2.g_hid[0].u_neuron.r_pot, -32768);
    bus2.i_spike_in = 4'b0110;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus2.o_done) begin lat = n; break; end
    end
    chk("sat run remaining latency", lat, 42);
    chk("pot recovered", dut2.g_hid[0].u_neuron.r_pot, -27688);
    chk("sat count0", bus2.o_spike_count[7:0], 255);
    chk("sat count1", bus2.o_spike_count[15:8], 255);
    chk("sat tie class", bus2.o_class_out, 0);
    chk("sat cvalid", bus2.o_class_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
